conv2_window_buf: RTL and testbench
===================================

// Module: conv2_window_buf
// PURPOSE
//  Streaming 5x5 window generator for layer conv2 (transmit side of the conv2_calc_* window interface).
//  - Accepts raster-order pixels from N_CH feature maps in parallel.
//  - For each fully valid KxK window, presents that window to all conv2_calc_* instances with a 1-cycle valid pulse.
//  - Sits between the pool1 output stage and the conv2_calc_* array. No padding; stride 1.
// PARAMETERS
//  DATA_W  12  pixel width, signed two's complement
//  IMG_W   12  input map width in pixels
//  IMG_H   12  input map height in pixels
//  K       5   kernel size; window side length
//  N_CH    3   input channels, processed in lockstep
// PORTS
//  clk            in   1                  rising-edge clock
//  rst_n          in   1                  reset, asynchronous, active-low
//  valid_in       in   1                  data_in holds one pixel of every channel this cycle
//  data_in        in   N_CH*DATA_W        ch c at [c*DATA_W +: DATA_W]; same (row,col) for all ch
//  win_out        out  N_CH*K*K*DATA_W    ch c tap i at [(c*K*K+i)*DATA_W +: DATA_W]
//  valid_out_buf  out  1                  1-cycle pulse: win_out holds a new valid window
//  frame_done     out  1                  only with CONV2_WIN_FRAME_DONE_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Clock and reset: one clock (clk). rst_n is asynchronous and active-low.
//  - Reset values: all shift stages 0, col=0, row=0, valid_out_buf=0, frame_done=0, win_out=0.
//  - Handshake: no backpressure. A pixel is accepted on every clk edge with valid_in=1.
//    Gaps of any length are allowed. Consumer must sample win_out on every valid_out_buf pulse.
//  - Storage: each channel has a shift chain of (K-1)*IMG_W+K stages (53 at defaults).
//    The chain shifts only on an accepted pixel.
//  - Tap mapping: tap i = r*K + cc. r=0 is the top (oldest) row; cc=0 is the leftmost (oldest) column.
//    Tap i equals stage (K-1-r)*IMG_W + (K-1-cc), where stage 0 is the newest pixel.
//    Tap 24 is the pixel just accepted; tap 0 is the pixel (K-1) rows up and (K-1) columns left.
//  - Position counters: col and row give the position of the next pixel to be accepted.
//    - col increments per accepted pixel and wraps at IMG_W-1 to 0, incrementing row.
//    - row wraps at IMG_H-1 to 0, which is the frame end.
//    - The next accepted pixel after a wrap starts a new frame.
//  - Window valid: valid_out_buf is registered. It is set to 1 on the edge that accepts a pixel at
//    (row>=K-1 && col>=K-1), and is 0 on all other edges.
//    - Latency: window and valid both appear in the cycle after the completing pixel's edge.
//    - win_out is the live tap view; it stays stable until the next accepted pixel.
//    - Per frame: (IMG_H-K+1)*(IMG_W-K+1) pulses = 64 at defaults.
//    - Back-to-back valid_in gives back-to-back pulses; do not feed toggle-style consumers
//      pulses on consecutive cycles.
//  - Frame boundary: the shift chain is not cleared between frames. Stale data never reaches a valid
//    window, because row>=K-1 implies K rows of the current frame have been loaded.
//  - Reset mid-frame: valid_out_buf drops asynchronously and the counters clear.
//    The first pixel after release is treated as (0,0).
//  - Arithmetic: no arithmetic on data; values pass through bit-exact.
//    Counter widths are $clog2(IMG_W) and $clog2(IMG_H).
// CONFIGURATION
//  - Macro CONV2_WIN_FRAME_DONE_EN.
//  - Defined: port frame_done exists. It is a registered 1-cycle pulse, set on the edge accepting
//    pixel (IMG_H-1, IMG_W-1), coincident with that frame's last valid_out_buf. Reset value 0.
//  - Undefined: the frame_done port and its register are absent. All other behaviour is identical.
// STRUCTURE
//  - Shared include conv2_defs.vh holds: DATA_W, IMG_W, IMG_H, K, N_CH defaults, and the
//    CHAIN_LEN=(K-1)*IMG_W+K localparam.
//  - Sub-module conv2_line_shift (DATA_W, CHAIN_LEN): one channel's enable-gated shift chain with
//    async reset, exposing all stages flat. Instantiate it N_CH times via generate.
//  - The top level holds the counters, valid/frame_done registers and the tap-mapping generate loop.
// TESTING
//  1 Ramp frame: ch0=row*12+col, ch1=ch0+256, ch2=-ch0, valid_in held 1.
//    -> First pulse arrives 1 cycle after pixel 52 is accepted.
//    -> ch0 tap0=0, tap24=52, tap5=12; ch1 tap0=256; ch2 tap24=-52 (12'hFCC).
//  2 Full frame (144 pixels).
//    -> Exactly 64 pulses; none while col<4 or row<4.
//    -> The last window has ch0 tap24=143 and tap0=91.
//  3 Random 50% valid_in gaps.
//    -> Windows and pulse count are identical to test 2.
//    -> win_out is unchanged during gaps; no pulse occurs during a gap.
//  4 rst_n low asynchronously after 30 pixels, then a fresh frame.
//    -> valid_out_buf=0 immediately.
//    -> First pulse comes after the 53rd new pixel, with tap24=52 of the new frame.
//  5 Two back-to-back frames, frame 2 offset by +1000.
//    -> Frame 2 first window: tap0=1000, tap24=1052; no pulse during frame 2 rows 0-3.
//  6 With CONV2_WIN_FRAME_DONE_EN defined, run two frames.
//    -> frame_done pulses exactly once per frame, in the same cycle as the 64th valid_out_buf.

Source files
------------

// File: rtl/conv2_window_buf_pkg.sv
// rtl/conv2_window_buf_pkg.sv - shared geometry and tap mapping for the conv2 window buffer
// Purpose: default DATA_W/IMG_W/IMG_H/K/N_CH, the per-channel shift chain length,
//          counter widths, and the window-tap to chain-stage mapping.
// Ports:   none (package).
package conv2_window_buf_pkg;

  localparam int DATA_W    = 12;
  localparam int IMG_W     = 12;
  localparam int IMG_H     = 12;
  localparam int K         = 5;
  localparam int N_CH      = 3;

  // Enough stages to hold K-1 full rows plus the K newest pixels of the current row.
  localparam int CHAIN_LEN = (K - 1) * IMG_W + K;

  localparam int COL_W     = $clog2(IMG_W);
  localparam int ROW_W     = $clog2(IMG_H);

  // Tap i = r*K + cc (r=0 top/oldest row, cc=0 leftmost/oldest column).
  // Stage 0 is the newest pixel, so tap K*K-1 maps to stage 0.
  function automatic int tap_stage(input int i);
    return (K - 1 - i / K) * IMG_W + (K - 1 - i % K);
  endfunction

endpackage

// File: rtl/conv2_window_buf_if.sv
// rtl/conv2_window_buf_if.sv - pixel-in / window-out bundle of the conv2 window buffer
// Purpose: groups the pixel input and window output signals.
// Ports:   valid_in, data_in (pixel producer -> buffer);
//          win_out, valid_out_buf, frame_done (buffer -> conv2_calc_* array).
//          frame_done exists only when CONV2_WIN_FRAME_DONE_EN is defined.
// Modports: master = pixel producer / window consumer side, slave = window buffer.
interface conv2_win_if;
  import conv2_window_buf_pkg::*;

  logic                          valid_in;
  logic [N_CH*DATA_W-1:0]        data_in;
  logic [N_CH*K*K*DATA_W-1:0]    win_out;
  logic                          valid_out_buf;

`ifdef CONV2_WIN_FRAME_DONE_EN
  logic                          frame_done;

  modport master (output valid_in, data_in, input win_out, valid_out_buf, frame_done);
  modport slave  (input valid_in, data_in, output win_out, valid_out_buf, frame_done);
`else
  modport master (output valid_in, data_in, input win_out, valid_out_buf);
  modport slave  (input valid_in, data_in, output win_out, valid_out_buf);
`endif

endinterface

// File: rtl/conv2_window_buf_line_shift.sv
// rtl/conv2_window_buf_line_shift.sv - one channel's enable-gated pixel shift chain
// Purpose: module conv2_line_shift; shifts din into stage 0 on every enabled edge,
//          exposing every stage flat (stage s at [s*DATA_W +: DATA_W]).
// Ports:   clk, rst_n (async active-low), en (shift enable), din (new pixel),
//          stages (CHAIN_LEN*DATA_W flat view, stage 0 = newest).
module conv2_line_shift #(
  parameter int DATA_W    = 12,
  parameter int CHAIN_LEN = 53
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [DATA_W-1:0]           din,
  output logic [CHAIN_LEN*DATA_W-1:0] stages
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else if (en) begin
      stages <= {stages[(CHAIN_LEN-1)*DATA_W-1:0], din};
    end
  end

endmodule

// File: rtl/conv2_window_buf.sv
// rtl/conv2_window_buf.sv - streaming KxK window generator feeding the conv2_calc_* array
// Purpose: accepts raster-order pixels of N_CH maps in lockstep and presents every fully
//          valid KxK window (no padding, stride 1) with a registered 1-cycle valid pulse.
// Ports:   clk, rst_n (async active-low), bus (conv2_win_if.slave: valid_in, data_in,
//          win_out, valid_out_buf, and frame_done when enabled).
// Config:  CONV2_WIN_FRAME_DONE_EN adds the frame_done pulse on the last pixel of a frame.
module conv2_window_buf
  import conv2_window_buf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  conv2_win_if.slave bus
);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             valid_q;
  logic             col_last;
  logic             row_last;
  logic             win_ready;

  assign col_last  = (col == COL_W'(IMG_W - 1));
  assign row_last  = (row == ROW_W'(IMG_H - 1));
  // The pixel at (row,col) completes a window once K rows and K columns of this frame are in.
  assign win_ready = (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.valid_in && win_ready;
      if (bus.valid_in) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  assign bus.valid_out_buf = valid_q;

`ifdef CONV2_WIN_FRAME_DONE_EN
  logic frame_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= bus.valid_in && row_last && col_last;
    end
  end

  assign bus.frame_done = frame_done_q;
`endif

  logic [CHAIN_LEN*DATA_W-1:0] stages [N_CH];
  // Stages between the window rows only carry line delay and are never tapped.
  logic [N_CH-1:0]             unused_stage_parity;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    conv2_line_shift #(
      .DATA_W    (DATA_W),
      .CHAIN_LEN (CHAIN_LEN)
    ) u_shift (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (bus.valid_in),
      .din    (bus.data_in[ch*DATA_W +: DATA_W]),
      .stages (stages[ch])
    );

    assign unused_stage_parity[ch] = ^stages[ch];

    for (genvar i = 0; i < K * K; i++) begin : g_tap
      assign bus.win_out[(ch*K*K+i)*DATA_W +: DATA_W] =
        stages[ch][tap_stage(i)*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_conv2_window_buf.sv
// tb/tb_conv2_window_buf.sv - directed self-checking bench for conv2_window_buf
module tb_conv2_window_buf;
  import conv2_window_buf_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv2_win_if bus();

  conv2_window_buf dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests    = 0;
  int failures = 0;

  int pulses, bad_pulses, win_errs, gap_pulses, gap_changes, first_n, fd_cnt, fd_bad;
  logic [DATA_W-1:0] first_t0, first_t24, first_t5, first_c1t0, first_c2t24;
  logic [DATA_W-1:0] last_t0, last_t24;

  // ch0 = v, ch1 = v + 256, ch2 = -v
  function automatic logic [N_CH*DATA_W-1:0] pix(input int v);
    logic [DATA_W-1:0] a, b, c;
    a = DATA_W'(v);
    b = DATA_W'(v + 256);
    c = DATA_W'(-v);
    return {c, b, a};
  endfunction

  function automatic logic [DATA_W-1:0] tap(input int c, input int i);
    return bus.win_out[(c*K*K+i)*DATA_W +: DATA_W];
  endfunction

  task automatic clear_stats();
    pulses = 0; bad_pulses = 0; win_errs = 0; gap_pulses = 0;
    gap_changes = 0; first_n = -1; fd_cnt = 0; fd_bad = 0;
  endtask

  task automatic idle_cycle();
    logic [N_CH*K*K*DATA_W-1:0] snap;
    snap = bus.win_out;
    @(negedge clk);
    bus.valid_in = 1'b0;
    @(posedge clk);
    #1;
    if (bus.valid_out_buf !== 1'b0) gap_pulses++;
    if (bus.win_out !== snap) gap_changes++;
`ifdef CONV2_WIN_FRAME_DONE_EN
    if (bus.frame_done !== 1'b0) fd_bad++;
`endif
  endtask

  // Feeds npix raster pixels of a frame whose ch0 value is offset + row*IMG_W + col,
  // comparing every presented window against the expected neighbourhood.
  task automatic run_frame(input int offset, input bit gaps, input int npix);
    for (int p = 0; p < npix; p++) begin
      int r, c, v;
      logic exp_pulse;
      logic [N_CH*DATA_W-1:0] e;
      r = p / IMG_W;
      c = p % IMG_W;
      if (gaps)
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) idle_cycle();
      @(negedge clk);
      bus.valid_in = 1'b1;
      bus.data_in  = pix(offset + p);
      @(posedge clk);
      #1;
      exp_pulse = (r >= K - 1) && (c >= K - 1);
      if (bus.valid_out_buf !== exp_pulse) bad_pulses++;
      if (bus.valid_out_buf === 1'b1) begin
        pulses++;
        if (first_n < 0) begin
          first_n     = p;
          first_t0    = tap(0, 0);
          first_t24   = tap(0, 24);
          first_t5    = tap(0, 5);
          first_c1t0  = tap(1, 0);
          first_c2t24 = tap(2, 24);
        end
        last_t0  = tap(0, 0);
        last_t24 = tap(0, 24);
        for (int i = 0; i < K * K; i++) begin
          v = offset + (r - (K - 1) + i / K) * IMG_W + (c - (K - 1) + i % K);
          e = pix(v);
          for (int ch = 0; ch < N_CH; ch++)
            if (tap(ch, i) !== e[ch*DATA_W +: DATA_W]) win_errs++;
        end
      end
`ifdef CONV2_WIN_FRAME_DONE_EN
      if (bus.frame_done === 1'b1) fd_cnt++;
      if (bus.frame_done !== (p == IMG_W * IMG_H - 1)) fd_bad++;
`endif
    end
  endtask

  task automatic test_reset();
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    rst_n = 1'b0;
    #12;
    tests++;
    if (bus.valid_out_buf !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b want 0", bus.valid_out_buf);
    end
    tests++;
    if (bus.win_out !== '0) begin
      failures++; $display("FAIL reset_win: got nonzero want 0");
    end
`ifdef CONV2_WIN_FRAME_DONE_EN
    tests++;
    if (bus.frame_done !== 1'b0) begin
      failures++; $display("FAIL reset_frame_done: got %b want 0", bus.frame_done);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ramp();
    clear_stats();
    run_frame(0, 1'b0, 53);
    tests++;
    if (first_n !== 52) begin
      failures++; $display("FAIL ramp_first_pulse_pixel: got %0d want 52", first_n);
    end
    tests++;
    if (first_t0 !== 12'd0) begin
      failures++; $display("FAIL ramp_ch0_tap0: got %h want 000", first_t0);
    end
    tests++;
    if (first_t24 !== 12'd52) begin
      failures++; $display("FAIL ramp_ch0_tap24: got %h want 034", first_t24);
    end
    tests++;
    if (first_t5 !== 12'd12) begin
      failures++; $display("FAIL ramp_ch0_tap5: got %h want 00c", first_t5);
    end
    tests++;
    if (first_c1t0 !== 12'd256) begin
      failures++; $display("FAIL ramp_ch1_tap0: got %h want 100", first_c1t0);
    end
    tests++;
    if (first_c2t24 !== 12'hFCC) begin
      failures++; $display("FAIL ramp_ch2_tap24: got %h want fcc", first_c2t24);
    end
    tests++;
    if (win_errs !== 0) begin
      failures++; $display("FAIL ramp_window_taps: got %0d tap errors want 0", win_errs);
    end
    // Pulse is high now; an async reset must kill it without waiting for an edge.
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.valid_out_buf !== 1'b0) begin
      failures++; $display("FAIL async_reset_valid: got %b want 0", bus.valid_out_buf);
    end
    tests++;
    if (bus.win_out !== '0) begin
      failures++; $display("FAIL async_reset_win: got nonzero want 0");
    end
    bus.valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_frame();
    clear_stats();
    run_frame(0, 1'b0, IMG_W * IMG_H);
    tests++;
    if (pulses !== 64) begin
      failures++; $display("FAIL full_pulse_count: got %0d want 64", pulses);
    end
    tests++;
    if (bad_pulses !== 0) begin
      failures++; $display("FAIL full_pulse_position: got %0d misplaced want 0", bad_pulses);
    end
    tests++;
    if (win_errs !== 0) begin
      failures++; $display("FAIL full_window_taps: got %0d tap errors want 0", win_errs);
    end
    tests++;
    if (last_t24 !== 12'd143) begin
      failures++; $display("FAIL full_last_tap24: got %0d want 143", last_t24);
    end
    tests++;
    if (last_t0 !== 12'd91) begin
      failures++; $display("FAIL full_last_tap0: got %0d want 91", last_t0);
    end
  endtask

  task automatic test_gaps();
    clear_stats();
    run_frame(0, 1'b1, IMG_W * IMG_H);
    tests++;
    if (pulses !== 64) begin
      failures++; $display("FAIL gaps_pulse_count: got %0d want 64", pulses);
    end
    tests++;
    if (bad_pulses !== 0) begin
      failures++; $display("FAIL gaps_pulse_position: got %0d misplaced want 0", bad_pulses);
    end
    tests++;
    if (win_errs !== 0) begin
      failures++; $display("FAIL gaps_window_taps: got %0d tap errors want 0", win_errs);
    end
    tests++;
    if (gap_pulses !== 0) begin
      failures++; $display("FAIL gaps_pulse_in_gap: got %0d want 0", gap_pulses);
    end
    tests++;
    if (gap_changes !== 0) begin
      failures++; $display("FAIL gaps_window_stable: got %0d changes want 0", gap_changes);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_stats();
    run_frame(0, 1'b0, 30);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.valid_out_buf !== 1'b0) begin
      failures++; $display("FAIL midreset_valid: got %b want 0", bus.valid_out_buf);
    end
    bus.valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    run_frame(500, 1'b0, IMG_W * IMG_H);
    tests++;
    if (first_n !== 52) begin
      failures++; $display("FAIL midreset_first_pulse_pixel: got %0d want 52", first_n);
    end
    tests++;
    if (first_t24 !== 12'd552) begin
      failures++; $display("FAIL midreset_first_tap24: got %0d want 552", first_t24);
    end
    tests++;
    if (pulses !== 64 || win_errs !== 0) begin
      failures++;
      $display("FAIL midreset_frame: got %0d pulses %0d tap errors want 64 and 0", pulses, win_errs);
    end
  endtask

  task automatic test_back_to_back();
    clear_stats();
    run_frame(0, 1'b0, IMG_W * IMG_H);
    clear_stats();
    run_frame(1000, 1'b0, IMG_W * IMG_H);
    tests++;
    if (first_t0 !== 12'd1000) begin
      failures++; $display("FAIL b2b_first_tap0: got %0d want 1000", first_t0);
    end
    tests++;
    if (first_t24 !== 12'd1052) begin
      failures++; $display("FAIL b2b_first_tap24: got %0d want 1052", first_t24);
    end
    tests++;
    if (bad_pulses !== 0) begin
      failures++; $display("FAIL b2b_pulse_position: got %0d misplaced want 0", bad_pulses);
    end
    tests++;
    if (pulses !== 64 || win_errs !== 0) begin
      failures++;
      $display("FAIL b2b_frame2: got %0d pulses %0d tap errors want 64 and 0", pulses, win_errs);
    end
  endtask

`ifdef CONV2_WIN_FRAME_DONE_EN
  task automatic test_frame_done();
    int total;
    clear_stats();
    run_frame(0, 1'b0, IMG_W * IMG_H);
    run_frame(2000, 1'b1, IMG_W * IMG_H);
    total = fd_cnt;
    tests++;
    if (total !== 2) begin
      failures++; $display("FAIL frame_done_count: got %0d want 2", total);
    end
    tests++;
    if (fd_bad !== 0) begin
      failures++; $display("FAIL frame_done_position: got %0d misplaced want 0", fd_bad);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ramp();
    test_full_frame();
    test_gaps();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef CONV2_WIN_FRAME_DONE_EN
    test_frame_done();
`endif
    @(negedge clk);
    bus.valid_in = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  // Safety net: the whole run is a few thousand cycles.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, tests run %0d", tests);
    $fatal(1);
  end

endmodule
